tdc_stream_tx: RTL and testbench
================================

// Module: tdc_stream_tx
// PURPOSE
// Transmit end of the histogram-builder input stream (wrEn/data). Buffers per-pixel TDC timestamps
// from the front-end (valid/ready), then replays them in the pixel-interleaved order the builder
// expects: ACQ_NUM acquisitions x PIXEL_NUM one-cycle slots, with idle gaps between acquisitions.
// Sits between TDC front-end and hisBuilderFSM; data/wrEn connect directly to its data/wrEn inputs.
// PARAMETERS
// NP          10  timestamp width (matches `Np)
// PIXEL_NUM   6   slots per acquisition (matches `PIXEL_NUM)
// ACQ_NUM     2   acquisitions per frame (matches `ACQ_NUM)
// GAP_CYCLES  4   idle cycles between acquisitions; 0 allowed
// FIFO_DEPTH  16  timestamp buffer entries, power of two
// PORTS
// clk       in   1                clock, all logic rising-edge
// res       in   1                reset, synchronous, active-high
// start     in   1                frame start pulse; honoured only in IDLE
// tdcValid  in   1                front-end timestamp valid
// tdcReady  out  1                buffer can accept (= !full)
// tdcData   in   NP               timestamp
// tdcNoHit  in   1                qualifies tdcData: no photon in this slot
// wrEn      out  1                slot strobe to builder
// data      out  NP               slot timestamp; NO_HIT_CODE (0) when no hit
// pixIdx    out  $clog2(PIXEL_NUM) pixel index of current slot
// acqIdx    out  $clog2(ACQ_NUM)  acquisition index of current slot
// busy      out  1                frame in progress (state != IDLE)
// done      out  1                one-cycle pulse after final slot
// underrun  out  1                sticky: a slot was emitted from empty buffer
// BEHAVIOUR
// - Reset: wrEn=0, data=0, pixIdx=0, acqIdx=0, busy=0, done=0, underrun=0, FIFO flushed, state IDLE.
//   res mid-frame aborts immediately; no partial slots after the reset edge.
// - Push: tdcValid && tdcReady on an edge stores {tdcNoHit ? 0 : tdcData}. Push accepted in any state.
// - States: IDLE -> STREAM on start (clears counters, clears underrun).
//   STREAM: every edge wrEn<=1, data<=FIFO head (pop) or 0 if empty (set underrun), pixIdx/acqIdx<=slot.
//     Last pixel of acquisition: acq<ACQ_NUM-1 -> GAP (or straight to next STREAM slot if GAP_CYCLES=0);
//     last pixel of last acquisition -> DONE.
//   GAP: wrEn<=0, data<=0 for exactly GAP_CYCLES edges, then STREAM with pixel 0, acq+1.
//   DONE: one edge: wrEn<=0, data<=0, done<=1, -> IDLE; done clears on following edge.
// - Timing: start sampled at edge E0 -> first slot registered at E1. Frame = ACQ_NUM*PIXEL_NUM +
//   (ACQ_NUM-1)*GAP_CYCLES edges of activity after E0; done high the cycle after last wrEn.
// - start while busy ignored (no restart, no counter change).
// - Push and pop same edge: occupancy unchanged. Push into empty FIFO is not bypassed to the same slot.
// - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits; tdcReady low when count=DEPTH.
// - Outputs all registered; no combinational path input->output except tdcReady (from count).
// STRUCTURE
// - Package dtof_stream_pkg: NP, PIXEL_NUM, ACQ_NUM, NO_HIT_CODE='0, typedef enum {IDLE,STREAM,GAP,DONE}.
// - Sub-module tdc_sync_fifo (single-clock, sync res, push/pop/full/empty/count, show-ahead head).
// - Top holds FSM, pixel/acq/gap counters, output registers.
// TESTING
// - Reset: res=1 3 cycles -> wrEn=0, data=0, busy=0, done=0, underrun=0, tdcReady=1.
// - Prefill 12 values (108,511,1022,200,90,511,...) then start -> E1..E6 wrEn=1 in order, E7..E10
//   wrEn=0, E11..E16 remaining 6 values, E17 done=1 busy->0, 12 strobes total, underrun=0.
// - Start with empty FIFO -> 12 slots data=0, underrun=1 and stays 1 until next start.
// - Push 16 values while IDLE -> tdcReady=0, 17th value held by front-end, accepted after first pop.
// - tdcNoHit=1 with tdcData=300 -> corresponding slot data=0, wrEn=1.
// - res asserted during GAP -> next cycle wrEn=0, busy=0, FIFO empty; new start restarts pixIdx=0, acqIdx=0.
// - start pulsed during STREAM -> ignored; frame length and done timing unchanged.

Source files
------------

// File: rtl/dtof_stream_pkg.sv
// -----------------------------------------------------------------------------
// dtof_stream_pkg
// Shared constants and types for the TDC timestamp stream that feeds the
// histogram builder.
//   NP          : timestamp width
//   PIXEL_NUM   : slots per acquisition
//   ACQ_NUM     : acquisitions per frame
//   NO_HIT_CODE : timestamp value that stands for "no photon in this slot"
//   tx_state_e  : transmitter FSM states
// -----------------------------------------------------------------------------
package dtof_stream_pkg;

    localparam int NP        = 10;
    localparam int PIXEL_NUM = 6;
    localparam int ACQ_NUM   = 2;

    localparam logic [NP-1:0] NO_HIT_CODE = '0;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        DONE
    } tx_state_e;

endpackage

// File: rtl/tdc_sync_fifo.sv
// -----------------------------------------------------------------------------
// tdc_sync_fifo
// Single-clock timestamp buffer with a show-ahead head: the oldest entry is
// always visible on head while the buffer is not empty, and pop retires it.
// Ports:
//   clk     in   rising-edge clock
//   res     in   synchronous active-high reset (flushes pointers and count)
//   push    in   write wr_data (ignored while full)
//   wr_data in   WIDTH-bit entry to store
//   pop     in   retire head (ignored while empty)
//   head    out  oldest stored entry
//   full    out  count == DEPTH
//   empty   out  count == 0
//   count   out  occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module tdc_sync_fifo
    import dtof_stream_pkg::*;
#(
    parameter int WIDTH = NP,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
    // the natural binary overflow the modulo-DEPTH wrap.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; a flush only clears pointers and
    // count, and stale entries are never visible because empty gates head use.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/tdc_stream_tx.sv
// -----------------------------------------------------------------------------
// tdc_stream_tx
// Buffers per-pixel TDC timestamps from the front-end and replays them to the
// histogram builder as ACQ_NUM acquisitions of PIXEL_NUM one-cycle slots, with
// GAP_CYCLES idle cycles between acquisitions.
// Ports:
//   clk       in   rising-edge clock
//   res       in   synchronous active-high reset; aborts a frame immediately
//   start     in   frame start pulse, honoured only while idle
//   tdcValid  in   front-end timestamp valid
//   tdcReady  out  buffer can accept (= !full), the only combinational output
//   tdcData   in   timestamp
//   tdcNoHit  in   tdcData carries no photon; stored as NO_HIT_CODE
//   wrEn      out  slot strobe to the builder
//   data      out  slot timestamp, NO_HIT_CODE when idle or buffer empty
//   pixIdx    out  pixel index of the current slot
//   acqIdx    out  acquisition index of the current slot
//   busy      out  frame in progress
//   done      out  one-cycle pulse after the final slot
//   underrun  out  sticky: a slot was emitted from an empty buffer
// -----------------------------------------------------------------------------
module tdc_stream_tx
    import dtof_stream_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          start,
    input  logic                          tdcValid,
    output logic                          tdcReady,
    input  logic [NP-1:0]                 tdcData,
    input  logic                          tdcNoHit,
    output logic                          wrEn,
    output logic [NP-1:0]                 data,
    output logic [$clog2(PIXEL_NUM)-1:0]  pixIdx,
    output logic [$clog2(ACQ_NUM)-1:0]    acqIdx,
    output logic                          busy,
    output logic                          done,
    output logic                          underrun
);

    localparam int PIX_W = $clog2(PIXEL_NUM);
    localparam int ACQ_W = $clog2(ACQ_NUM);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXEL_NUM - 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_e         state, state_nxt;
    logic [PIX_W-1:0]  pix_cnt, pix_cnt_nxt;
    logic [ACQ_W-1:0]  acq_cnt, acq_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;

    logic              wr_en_nxt;
    logic [NP-1:0]     data_nxt;
    logic [PIX_W-1:0]  pix_idx_nxt;
    logic [ACQ_W-1:0]  acq_idx_nxt;
    logic              done_nxt;
    logic              underrun_nxt;

    logic              fifo_pop;
    logic [NP-1:0]     fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [NP-1:0]     push_data;

    assign push_data = tdcNoHit ? NO_HIT_CODE : tdcData;
    assign tdcReady  = !fifo_full;

    tdc_sync_fifo #(
        .WIDTH (NP),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .res     (res),
        .push    (tdcValid),
        .wr_data (push_data),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state and next-output logic. The pop reads the pre-edge head, so a
    // value pushed on the same edge into an empty buffer waits for a later slot.
    // NOTE: every signal written here gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt    = state;
        pix_cnt_nxt  = pix_cnt;
        acq_cnt_nxt  = acq_cnt;
        gap_cnt_nxt  = gap_cnt;
        wr_en_nxt    = 1'b0;
        data_nxt     = NO_HIT_CODE;
        pix_idx_nxt  = pixIdx;
        acq_idx_nxt  = acqIdx;
        done_nxt     = 1'b0;
        underrun_nxt = underrun;
        fifo_pop     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = STREAM;
                    pix_cnt_nxt  = '0;
                    acq_cnt_nxt  = '0;
                    gap_cnt_nxt  = '0;
                    underrun_nxt = 1'b0;
                end
            end

            STREAM: begin
                wr_en_nxt   = 1'b1;
                pix_idx_nxt = pix_cnt;
                acq_idx_nxt = acq_cnt;
                if (fifo_empty) begin
                    underrun_nxt = 1'b1;
                end else begin
                    data_nxt = fifo_head;
                    fifo_pop = 1'b1;
                end

                if (pix_cnt == PIX_LAST) begin
                    pix_cnt_nxt = '0;
                    if (acq_cnt == ACQ_LAST) begin
                        state_nxt = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        // No gap: next acquisition's pixel 0 follows directly.
                        acq_cnt_nxt = acq_cnt + ACQ_W'(1);
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = '0;
                    end
                end else begin
                    pix_cnt_nxt = pix_cnt + PIX_W'(1);
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt   = STREAM;
                    acq_cnt_nxt = acq_cnt + ACQ_W'(1);
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end

            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // busy follows the state being entered so it rises with the start edge and
    // falls on the same edge that raises done.
    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            acq_cnt  <= '0;
            gap_cnt  <= '0;
            wrEn     <= 1'b0;
            data     <= NO_HIT_CODE;
            pixIdx   <= '0;
            acqIdx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            pix_cnt  <= pix_cnt_nxt;
            acq_cnt  <= acq_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            wrEn     <= wr_en_nxt;
            data     <= data_nxt;
            pixIdx   <= pix_idx_nxt;
            acqIdx   <= acq_idx_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            underrun <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_tdc_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_tdc_stream_tx
// Self-checking bench for tdc_stream_tx. A reference model derives the slot
// schedule from the frame arithmetic (offset since start, acquisition period)
// and the buffer contents from a plain queue; expected slots go into a
// scoreboard queue that a separate monitor drains whenever wrEn is seen.
// -----------------------------------------------------------------------------
module tb_tdc_stream_tx;
    import dtof_stream_pkg::*;

    localparam int GAP       = 4;
    localparam int DEPTH     = 16;
    localparam int PERIOD    = PIXEL_NUM + GAP;
    localparam int FRAME_LEN = ACQ_NUM * PIXEL_NUM + (ACQ_NUM - 1) * GAP;
    localparam int PIX_W     = $clog2(PIXEL_NUM);
    localparam int ACQ_W     = $clog2(ACQ_NUM);

    logic              clk = 1'b0;
    logic              res = 1'b1;
    logic              start = 1'b0;
    logic              tdcValid = 1'b0;
    logic              tdcReady;
    logic [NP-1:0]     tdcData = '0;
    logic              tdcNoHit = 1'b0;
    logic              wrEn;
    logic [NP-1:0]     data;
    logic [PIX_W-1:0]  pixIdx;
    logic [ACQ_W-1:0]  acqIdx;
    logic              busy;
    logic              done;
    logic              underrun;

    always #5 clk = ~clk;

    tdc_stream_tx #(
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .tdcValid (tdcValid),
        .tdcReady (tdcReady),
        .tdcData  (tdcData),
        .tdcNoHit (tdcNoHit),
        .wrEn     (wrEn),
        .data     (data),
        .pixIdx   (pixIdx),
        .acqIdx   (acqIdx),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int data;
        int pix;
        int acq;
    } slot_t;

    slot_t sb_q[$];
    int    model_q[$];

    bit mon_en    = 1'b0;
    bit m_busy    = 1'b0;
    int m_off     = 0;
    bit exp_wren  = 1'b0;
    bit exp_busy  = 1'b0;
    bit exp_done  = 1'b0;
    bit exp_under = 1'b0;
    bit exp_ready = 1'b1;

    // Reference model: one step per rising edge, using the inputs held since
    // the preceding falling edge.
    always @(posedge clk) begin : model
        int    pre_sz;
        int    t;
        slot_t s;
        pre_sz   = model_q.size();
        exp_wren = 1'b0;
        exp_done = 1'b0;
        if (res) begin
            model_q.delete();
            m_busy    = 1'b0;
            exp_under = 1'b0;
        end else begin
            if (m_busy) begin
                m_off++;
                if (m_off <= FRAME_LEN) begin
                    t = m_off - 1;
                    if ((t % PERIOD) < PIXEL_NUM) begin
                        s.pix = t % PERIOD;
                        s.acq = t / PERIOD;
                        if (pre_sz > 0) begin
                            s.data = model_q.pop_front();
                        end else begin
                            s.data    = 0;
                            exp_under = 1'b1;
                        end
                        sb_q.push_back(s);
                        exp_wren = 1'b1;
                    end
                end else begin
                    exp_done = 1'b1;
                    m_busy   = 1'b0;
                end
            end else if (start) begin
                m_busy    = 1'b1;
                m_off     = 0;
                exp_under = 1'b0;
            end
            if (tdcValid && pre_sz < DEPTH)
                model_q.push_back(tdcNoHit ? 0 : int'(tdcData));
        end
        exp_busy  = m_busy;
        exp_ready = (model_q.size() < DEPTH);
        mon_en    = 1'b1;
    end

    // Monitor: compares every falling edge; drains the scoreboard on wrEn.
    always @(negedge clk) begin : monitor
        slot_t s;
        if (mon_en) begin
            check("wrEn", wrEn, exp_wren);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("underrun", underrun, exp_under);
            check("tdcReady", tdcReady, exp_ready);
            if (wrEn === 1'b1) begin
                strobes++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: actual=wrEn=1 expected=no slot (t=%0t)", $time);
                end else begin
                    s = sb_q.pop_front();
                    check("slot_data", data, s.data);
                    check("slot_pixIdx", pixIdx, s.pix);
                    check("slot_acqIdx", acqIdx, s.acq);
                end
            end else begin
                check("idle_data", data, 0);
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        res = 1'b1;
        repeat (n) @(negedge clk);
        check("reset_pixIdx", pixIdx, 0);
        check("reset_acqIdx", acqIdx, 0);
        res = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_val(input int v, input bit nohit);
        int guard;
        guard = 0;
        @(negedge clk);
        tdcValid = 1'b1;
        tdcData  = NP'(v);
        tdcNoHit = nohit;
        while (tdcReady !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: actual=tdcReady low for %0d cycles expected=accepted (t=%0t)", guard, $time);
        end
        @(posedge clk);
        #1;
        tdcValid = 1'b0;
        tdcNoHit = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push_val($urandom_range(0, 1023), 1'b0);
    endtask

    int prefill [12] = '{108, 511, 1022, 200, 90, 511, 7, 300, 1023, 0, 64, 999};
    int strobe_base;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state.
        do_reset(3);

        // Prefilled frame: order, gap timing, done, strobe count.
        foreach (prefill[i]) push_val(prefill[i], 1'b0);
        strobe_base = strobes;
        pulse_start();
        wait_done(40);
        check("frame_strobes", strobes - strobe_base, ACQ_NUM * PIXEL_NUM);

        // Empty buffer: zero slots and sticky underrun until the next start.
        pulse_start();
        wait_done(40);
        repeat (5) @(negedge clk);

        // Fill to full while idle; 17th value waits for the first pop.
        push_random(DEPTH);
        fork
            pulse_start();
            push_val(777, 1'b0);
        join
        wait_done(60);

        // No-hit qualification.
        do_reset(1);
        for (int i = 0; i < 12; i++)
            push_val((i == 2 || i == 7) ? 300 : $urandom_range(1, 1023), (i == 2 || i == 7));
        pulse_start();
        wait_done(40);

        // Reset during the inter-acquisition gap, then restart from empty.
        push_random(12);
        pulse_start();
        repeat (8) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        pulse_start();
        wait_done(40);

        // start while busy is ignored.
        push_random(12);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(40);

        // Randomized traffic with concurrent push/pop and backpressure.
        for (int f = 0; f < 4; f++) begin
            fork
                begin
                    for (int i = 0; i < 50; i++) begin
                        @(negedge clk);
                        tdcValid = ($urandom_range(0, 3) != 0);
                        tdcData  = NP'($urandom_range(0, 1023));
                        tdcNoHit = ($urandom_range(0, 4) == 0);
                    end
                    @(negedge clk);
                    tdcValid = 1'b0;
                    tdcNoHit = 1'b0;
                end
                begin
                    repeat ($urandom_range(0, 12)) @(negedge clk);
                    pulse_start();
                    wait_done(60);
                end
            join
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
